// File: rtl/pixel_tot_buffer.sv
// Per-pixel Time-over-Threshold capture with a one-hot latency buffer.
// Leading/trailing edges of the masked, armed discriminator are found with a
// two-stage pipeline. ToT is counted in Clk cycles and written into the slot
// that was selected by LeAddr at the leading edge. The all-ones code marks an
// empty slot, so the counter saturates one below it.
module pixel_tot_buffer #(
  parameter int MEM   = 4,
  parameter int TOT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Disc,
  input  logic             Mask,
  input  logic             BinMode,
  input  logic [MEM-1:0]   LeAddr,
  input  logic             LE,
  input  logic [MEM-1:0]   Read,
  output logic             WriteLe,
  output logic             Busy,
  output logic             HitLost,
  output logic [TOT_W-1:0] Data
);

  localparam logic [TOT_W-1:0] NO_HIT  = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = ~TOT_W'(1);

  logic             d1_q;
  logic             d2_q;
  logic             arm_q;
  logic [TOT_W-1:0] cnt_q;
  logic [MEM-1:0]   addr_q;
  logic             busy_q;
  logic             hit_lost_q;
  logic [TOT_W-1:0] slot_q [MEM];

  logic disc_raw;
  logic disc_eff;
  logic write_le;
  logic te;
  logic te_wr;
  logic le_onehot;
  logic alloc;

  assign disc_raw  = Disc & ~Mask;
  assign disc_eff  = disc_raw & arm_q;
  assign write_le  = d1_q & ~d2_q;
  assign te        = d2_q & ~d1_q;
  assign te_wr     = te & busy_q;
  assign le_onehot = (LeAddr != '0) && ((LeAddr & (LeAddr - 1'b1)) == '0);
  // A successful allocation protects the selected slot from a same-cycle clear.
  assign alloc     = write_le & le_onehot;

  assign WriteLe = write_le;
  assign Busy    = busy_q;
  assign HitLost = hit_lost_q;

  // Edge-detect pipeline; arm stays low until Disc has been seen low once,
  // so a Disc held high across reset release cannot fake a leading edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      d1_q  <= 1'b0;
      d2_q  <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      d1_q <= disc_eff;
      d2_q <= d1_q;
      if (!disc_raw) arm_q <= 1'b1;
    end
  end

  // Hit bookkeeping: slot allocation, saturating ToT counter, Busy and HitLost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      hit_lost_q <= 1'b0;
    end else begin
      hit_lost_q <= 1'b0;
      if (write_le) begin
        if (le_onehot) begin
          addr_q <= LeAddr;
          cnt_q  <= '0;
          busy_q <= 1'b1;
        end else begin
          hit_lost_q <= 1'b1;
          addr_q     <= '0;
        end
      end else if (d1_q && (cnt_q != TOT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (te_wr) busy_q <= 1'b0;
    end
  end

  // Latency-buffer slots: trailing-edge write beats a clear to the same slot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < MEM; k++) slot_q[k] <= NO_HIT;
    end else begin
      for (int k = 0; k < MEM; k++) begin
        if (te_wr && addr_q[k]) begin
          slot_q[k] <= BinMode ? '0 : cnt_q;
        end else if (LE && LeAddr[k] && !alloc) begin
          slot_q[k] <= NO_HIT;
        end
      end
    end
  end

  // Read port: OR of every selected slot, no arbitration.
  always_comb begin
    Data = '0;
    for (int k = 0; k < MEM; k++) begin
      if (Read[k]) Data = Data | slot_q[k];
    end
  end

endmodule

// File: tb/tb_pixel_tot_buffer.sv
module tb_pixel_tot_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: MEM=4, TOT_W=4
  logic       a_reset, a_disc, a_mask, a_bin, a_le;
  logic [3:0] a_lea, a_read, a_data;
  logic       a_wle, a_busy, a_hl;

  // Instance B: MEM=8, TOT_W=6
  logic       b_reset, b_disc, b_mask, b_bin, b_le;
  logic [7:0] b_lea, b_read;
  logic [5:0] b_data;
  logic       b_wle, b_busy, b_hl;

  pixel_tot_buffer #(.MEM(4), .TOT_W(4)) u_a (
    .Clk(clk), .Reset(a_reset), .Disc(a_disc), .Mask(a_mask), .BinMode(a_bin),
    .LeAddr(a_lea), .LE(a_le), .Read(a_read),
    .WriteLe(a_wle), .Busy(a_busy), .HitLost(a_hl), .Data(a_data)
  );

  pixel_tot_buffer #(.MEM(8), .TOT_W(6)) u_b (
    .Clk(clk), .Reset(b_reset), .Disc(b_disc), .Mask(b_mask), .BinMode(b_bin),
    .LeAddr(b_lea), .LE(b_le), .Read(b_read),
    .WriteLe(b_wle), .Busy(b_busy), .HitLost(b_hl), .Data(b_data)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Row = inputs applied at a negedge; expected outputs are sampled 1 ns later,
  // i.e. the state left by all earlier rising edges.
  typedef struct {
    logic       rst;
    logic       disc;
    logic       chk;
    logic       wle;
    logic       busy;
    logic       hl;
    logic [3:0] data;
  } vec_t;

  vec_t vecs [21];

  task automatic set_row(input int i, input logic rst, input logic disc, input logic chk,
                         input logic wle, input logic busy, input logic hl, input logic [3:0] data);
    vecs[i].rst  = rst;
    vecs[i].disc = disc;
    vecs[i].chk  = chk;
    vecs[i].wle  = wle;
    vecs[i].busy = busy;
    vecs[i].hl   = hl;
    vecs[i].data = data;
  endtask

  task automatic drive_a(input logic disc, input logic mask, input logic [3:0] lea, input logic le);
    @(negedge clk);
    a_disc = disc;
    a_mask = mask;
    a_lea  = lea;
    a_le   = le;
    #1;
  endtask

  task automatic pulse_a(input int n, input logic [3:0] lea,
                         output int wle_n, output int busy_n, output int hl_n);
    wle_n = 0; busy_n = 0; hl_n = 0;
    for (int i = 0; i < n + 4; i++) begin
      drive_a(i < n, 1'b0, lea, 1'b0);
      wle_n  += int'(a_wle);
      busy_n += int'(a_busy);
      hl_n   += int'(a_hl);
    end
  endtask

  task automatic pulse_b(input int n, input logic [7:0] lea, output int busy_n);
    busy_n = 0;
    for (int i = 0; i < n + 4; i++) begin
      @(negedge clk);
      b_disc = (i < n);
      b_lea  = lea;
      #1;
      busy_n += int'(b_busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bz, h;
    a_reset = 1'b1; a_disc = 1'b1; a_mask = 1'b0; a_bin = 1'b0; a_le = 1'b0;
    a_lea = 4'b0010; a_read = 4'b0010;
    b_reset = 1'b1; b_disc = 1'b0; b_mask = 1'b0; b_bin = 1'b0; b_le = 1'b0;
    b_lea = 8'h00; b_read = 8'h00;

    // Disc held through reset release, then a clean 5-cycle pulse into slot1.
    set_row(0, 1, 1, 0, 0, 0, 0, 4'd15);
    set_row(1, 1, 1, 1, 0, 0, 0, 4'd15);
    for (int i = 2; i <= 11; i++) set_row(i, 0, 1, 1, 0, 0, 0, 4'd15);
    set_row(12, 0, 0, 1, 0, 0, 0, 4'd15);
    set_row(13, 0, 1, 1, 0, 0, 0, 4'd15);
    set_row(14, 0, 1, 1, 1, 0, 0, 4'd15);
    set_row(15, 0, 1, 1, 0, 1, 0, 4'd15);
    set_row(16, 0, 1, 1, 0, 1, 0, 4'd15);
    set_row(17, 0, 1, 1, 0, 1, 0, 4'd15);
    set_row(18, 0, 0, 1, 0, 1, 0, 4'd15);
    set_row(19, 0, 0, 1, 0, 1, 0, 4'd15);
    set_row(20, 0, 0, 1, 0, 0, 0, 4'd4);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      a_reset = vecs[i].rst;
      a_disc  = vecs[i].disc;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d_wle", i),  a_wle,  vecs[i].wle);
        check($sformatf("row%0d_busy", i), a_busy, vecs[i].busy);
        check($sformatf("row%0d_hl", i),   a_hl,   vecs[i].hl);
        check($sformatf("row%0d_data", i), a_data, vecs[i].data);
      end
    end

    // Saturation: 40-cycle pulse into slot0.
    a_read = 4'b0001;
    pulse_a(40, 4'b0001, w, bz, h);
    check("sat_wle_count", w, 1);
    check("sat_busy_cycles", bz, 40);
    check("sat_hl_count", h, 0);
    check("sat_data", a_data, 14);

    // Binary mode, then latency-expired clear.
    a_bin = 1'b1;
    pulse_a(7, 4'b0100, w, bz, h);
    a_bin = 1'b0;
    a_read = 4'b0100;
    #1;
    check("bin_data", a_data, 0);
    drive_a(1'b0, 1'b0, 4'b0100, 1'b1);
    drive_a(1'b0, 1'b0, 4'b0100, 1'b0);
    check("clear_data", a_data, 15);

    // Invalid LeAddr at leading edge.
    pulse_a(3, 4'b0000, w, bz, h);
    check("lost0_hl_count", h, 1);
    check("lost0_busy_cycles", bz, 0);
    check("lost0_wle_count", w, 1);
    pulse_a(3, 4'b0110, w, bz, h);
    check("lost6_hl_count", h, 1);
    check("lost6_busy_cycles", bz, 0);
    a_read = 4'b0001; #1;
    check("lost_slot0", a_data, 14);
    a_read = 4'b0010; #1;
    check("lost_slot1", a_data, 4);
    a_read = 4'b0100; #1;
    check("lost_slot2", a_data, 15);

    // te write to slot3 coincides with a clear of slot3.
    a_read = 4'b1000;
    for (int i = 0; i < 4; i++) drive_a(1'b1, 1'b0, 4'b1000, 1'b0);
    drive_a(1'b0, 1'b0, 4'b1000, 1'b0);
    drive_a(1'b0, 1'b0, 4'b1000, 1'b1);
    check("te_cycle_busy", a_busy, 1);
    drive_a(1'b0, 1'b0, 4'b1000, 1'b0);
    check("te_beats_clear", a_data, 3);
    drive_a(1'b0, 1'b0, 4'b1000, 1'b0);

    // Clear in the allocation cycle of the same slot is ignored.
    drive_a(1'b1, 1'b0, 4'b1000, 1'b0);
    drive_a(1'b1, 1'b0, 4'b1000, 1'b1);
    check("alloc_wle", a_wle, 1);
    drive_a(1'b1, 1'b0, 4'b1000, 1'b0);
    check("alloc_keeps_old", a_data, 3);
    for (int i = 0; i < 3; i++) drive_a(1'b1, 1'b0, 4'b1000, 1'b0);
    for (int i = 0; i < 4; i++) drive_a(1'b0, 1'b0, 4'b1000, 1'b0);
    check("alloc_new_tot", a_data, 5);

    // Mask rises on the 3rd cycle of a 10-cycle pulse.
    a_read = 4'b0001;
    for (int i = 0; i < 2; i++) drive_a(1'b1, 1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 8; i++) drive_a(1'b1, 1'b1, 4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) drive_a(1'b0, 1'b0, 4'b0001, 1'b0);
    check("mask_partial_tot", a_data, 1);

    // Wide instance: ToT k into slot k.
    @(negedge clk); b_reset = 1'b1;
    @(negedge clk); b_reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      pulse_b(k + 1, 8'(1 << k), bz);
      check($sformatf("b_busy_cycles%0d", k), bz, k + 1);
    end
    for (int k = 0; k < 8; k++) begin
      b_read = 8'(1 << k);
      #1;
      check($sformatf("b_slot%0d", k), b_data, k);
    end
    b_read = 8'b0000_0011; #1;
    check("b_or_read", b_data, 1);
    b_read = 8'h00; #1;
    check("b_no_read", b_data, 0);

    @(negedge clk); b_reset = 1'b1;
    @(negedge clk); b_reset = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      b_read = 8'(1 << k);
      #1;
      check($sformatf("b_reset_slot%0d", k), b_data, 63);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
